// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions used by the ALU datapath and the board front end.
// Only the opcode type is needed by the operand entry logic.
package cpu_types_pkg;

    typedef logic [3:0] aluop_t;

endpackage

// File: rtl/fpga_entry_pkg.sv
// Types and constants shared by the operand entry front end and its key debouncers.
// Holds the entry state encoding, button roles and the operand widening helper.
package fpga_entry_pkg;

    typedef enum logic [1:0] {
        ENTER_A  = 2'd0,
        ENTER_B  = 2'd1,
        ENTER_OP = 2'd2,
        SHOW     = 2'd3
    } entry_state_t;

    localparam int KEY_ENTER = 0;
    localparam int KEY_BACK  = 1;
    localparam int KEY_CLEAR = 3;

    localparam int DEBOUNCE_DEFAULT = 1000000;

    localparam int NUM_KEYS  = 4;
    localparam int NUM_SW    = 18;
    localparam int OPERAND_W = 17;
    localparam int WORD_W    = 32;

    // Switches carry a 17-bit unsigned operand; the upper word bits are zero.
    function automatic logic [WORD_W-1:0] operand_from_sw(input logic [OPERAND_W-1:0] sw);
        return {{(WORD_W-OPERAND_W){1'b0}}, sw};
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// One pushbutton: two-flop synchronizer, stability counter, debounced level
// and a single-cycle pulse when the debounced level falls (button pressed).
module key_debouncer
    import fpga_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q,  meta_d;
    logic             sync_q,  sync_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             press_q, press_d;

    // Any sample matching the accepted level restarts the stability count.
    always_comb begin
        meta_d  = key_raw;
        sync_d  = meta_q;
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q;
                press_d = level_q & ~sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign key_press = press_q;

endmodule

// File: rtl/fpga_operand_entry.sv
// Board input front end: synchronizes switches, debounces keys and walks the
// user through entering operand A, operand B and an ALU opcode.
module fpga_operand_entry
    import fpga_entry_pkg::*;
    import cpu_types_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic                CLOCK_50,
    input  logic                nRST,
    input  logic [NUM_KEYS-1:0] KEY,
    input  logic [NUM_SW-1:0]   SW,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [WORD_W-1:0]   port_a,
    output logic [WORD_W-1:0]   port_b,
    output aluop_t              aluop,
    output logic                exec_valid,
    output logic [1:0]          entry_state
);

    logic [NUM_KEYS-1:0] press;

    logic [NUM_SW-1:0] sw_meta_q, sw_meta_d;
    logic [NUM_SW-1:0] sw_sync_q, sw_sync_d;

    entry_state_t      state_q,      state_d;
    logic [WORD_W-1:0] port_a_q,     port_a_d;
    logic [WORD_W-1:0] port_b_q,     port_b_d;
    aluop_t            aluop_q,      aluop_d;
    logic              exec_valid_q, exec_valid_d;

    logic sw_unused;

    genvar k;
    generate
        for (k = 0; k < NUM_KEYS; k++) begin : g_key
            key_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_key_debouncer (
                .clk      (CLOCK_50),
                .rst_n    (nRST),
                .key_raw  (KEY[k]),
                .key_press(press[k])
            );
        end
    endgenerate

    // SW[17] is kept for the future register-load mode.
    assign sw_unused = sw_sync_q[NUM_SW-1];

    always_comb begin
        sw_meta_d = SW;
        sw_sync_d = sw_meta_q;
    end

    always_ff @(posedge CLOCK_50 or negedge nRST) begin
        if (!nRST) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
        end
    end

    // Clear outranks enter, which outranks back; only one action per cycle.
    always_comb begin
        state_d      = state_q;
        port_a_d     = port_a_q;
        port_b_d     = port_b_q;
        aluop_d      = aluop_q;
        exec_valid_d = 1'b0;
        if (press[KEY_CLEAR]) begin
            port_a_d = '0;
            port_b_d = '0;
            aluop_d  = '0;
            state_d  = ENTER_A;
        end else if (press[KEY_ENTER]) begin
            case (state_q)
                ENTER_A: begin
                    port_a_d = operand_from_sw(sw_sync_q[OPERAND_W-1:0]);
                    state_d  = ENTER_B;
                end
                ENTER_B: begin
                    port_b_d = operand_from_sw(sw_sync_q[OPERAND_W-1:0]);
                    state_d  = ENTER_OP;
                end
                ENTER_OP: begin
                    aluop_d      = aluop_t'(sw_sync_q[3:0]);
                    exec_valid_d = 1'b1;
                    state_d      = SHOW;
                end
                SHOW:    state_d = ENTER_A;
                default: state_d = ENTER_A;
            endcase
        end else if (press[KEY_BACK]) begin
            case (state_q)
                SHOW:     state_d = ENTER_OP;
                ENTER_OP: state_d = ENTER_B;
                ENTER_B:  state_d = ENTER_A;
                default:  state_d = ENTER_A;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge nRST) begin
        if (!nRST) begin
            state_q      <= ENTER_A;
            port_a_q     <= '0;
            port_b_q     <= '0;
            aluop_q      <= '0;
            exec_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            port_a_q     <= port_a_d;
            port_b_q     <= port_b_d;
            aluop_q      <= aluop_d;
            exec_valid_q <= exec_valid_d;
        end
    end

    assign key_press   = press;
    assign port_a      = port_a_q;
    assign port_b      = port_b_q;
    assign aluop       = aluop_q;
    assign exec_valid  = exec_valid_q;
    assign entry_state = state_q;

endmodule

// File: tb/tb_fpga_operand_entry.sv
// Directed bench for the operand entry front end with a short debounce window.
// Expected values are hand-computed from the entry sequence and debounce timing.
module tb_fpga_operand_entry;

    localparam int DB = 4;

    logic        CLOCK_50;
    logic        nRST;
    logic [3:0]  KEY;
    logic [17:0] SW;
    logic [3:0]  key_press;
    logic [31:0] port_a;
    logic [31:0] port_b;
    logic [3:0]  aluop;
    logic        exec_valid;
    logic [1:0]  entry_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pressCnt [4] = '{0, 0, 0, 0};
    int pressCyc [4] = '{0, 0, 0, 0};
    int evCnt = 0;

    fpga_operand_entry #(
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .nRST       (nRST),
        .KEY        (KEY),
        .SW         (SW),
        .key_press  (key_press),
        .port_a     (port_a),
        .port_b     (port_b),
        .aluop      (aluop),
        .exec_valid (exec_valid),
        .entry_state(entry_state)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Cycle index advances on every active edge.
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Pulse monitor samples on the falling edge, away from updates.
    always @(negedge CLOCK_50) begin
        for (int k = 0; k < 4; k++) begin
            if (key_press[k]) begin
                pressCnt[k] = pressCnt[k] + 1;
                pressCyc[k] = cyc;
            end
        end
        if (exec_valid) evCnt = evCnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] key, input logic [17:0] sw, input int cycles);
        KEY = key;
        SW  = sw;
        repeat (cycles) @(negedge CLOCK_50);
    endtask

    task automatic pressEnter(input logic [17:0] sw);
        applyStimulus(4'hE, sw, 10);
        applyStimulus(4'hF, sw, 10);
    endtask

    int c0, p0, p3, e0c, rel;

    initial begin
        KEY  = 4'hF;
        SW   = '0;
        nRST = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        checkOutput("rst_port_a", port_a, 32'h0);
        checkOutput("rst_press", {28'h0, key_press}, 32'h0);
        nRST = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        checkOutput("rel_state", {30'h0, entry_state}, 32'd0);
        checkOutput("rel_port_b", port_b, 32'h0);
        checkOutput("rel_aluop", {28'h0, aluop}, 32'h0);
        checkOutput("rel_exec", {31'h0, exec_valid}, 32'h0);

        // Single press: pulse DB+1 edges after the first low sample.
        p0 = pressCnt[0];
        c0 = cyc;
        applyStimulus(4'hE, 18'h12345, 10);
        checkOutput("t2_pulses", pressCnt[0] - p0, 32'd1);
        checkOutput("t2_pulse_edge", pressCyc[0] - c0, 32'd6);
        checkOutput("t2_port_a", port_a, 32'h00012345);
        checkOutput("t2_state", {30'h0, entry_state}, 32'd1);
        applyStimulus(4'hF, 18'h12345, 10);
        checkOutput("t2_release", pressCnt[0] - p0, 32'd1);

        // Bounce shorter than the window never registers.
        p0 = pressCnt[0];
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'hE, 18'h00001, 2);
            applyStimulus(4'hF, 18'h00001, 2);
        end
        applyStimulus(4'hF, 18'h00001, 10);
        checkOutput("t3_pulses", pressCnt[0] - p0, 32'd0);
        checkOutput("t3_state", {30'h0, entry_state}, 32'd1);
        checkOutput("t3_port_a", port_a, 32'h00012345);

        // Full entry sequence starting from a cleared state.
        applyStimulus(4'h7, 18'h0, 10);
        applyStimulus(4'hF, 18'h0, 10);
        checkOutput("t4_clr_state", {30'h0, entry_state}, 32'd0);
        checkOutput("t4_clr_a", port_a, 32'h0);
        e0c = evCnt;
        pressEnter(18'h0000F);
        pressEnter(18'h00003);
        pressEnter(18'h2FFF2);
        checkOutput("t4_port_a", port_a, 32'hF);
        checkOutput("t4_port_b", port_b, 32'h3);
        checkOutput("t4_aluop", {28'h0, aluop}, 32'h2);
        checkOutput("t4_exec_cycles", evCnt - e0c, 32'd1);
        checkOutput("t4_state", {30'h0, entry_state}, 32'd3);
        pressEnter(18'h00000);
        checkOutput("t4_wrap_state", {30'h0, entry_state}, 32'd0);
        checkOutput("t4_keep_a", port_a, 32'hF);
        checkOutput("t4_keep_b", port_b, 32'h3);
        checkOutput("t4_keep_op", {28'h0, aluop}, 32'h2);

        // Clear and enter land in the same cycle: clear wins.
        pressEnter(18'h00055);
        checkOutput("t5_a_loaded", port_a, 32'h55);
        checkOutput("t5_in_b", {30'h0, entry_state}, 32'd1);
        p0 = pressCnt[0];
        p3 = pressCnt[3];
        applyStimulus(4'b0110, 18'h00077, 10);
        applyStimulus(4'hF, 18'h00077, 10);
        checkOutput("t5_both_pulsed", (pressCnt[0] - p0) + (pressCnt[3] - p3), 32'd2);
        checkOutput("t5_same_edge", {31'h0, pressCyc[0] == pressCyc[3]}, 32'd1);
        checkOutput("t5_clr_a", port_a, 32'h0);
        checkOutput("t5_clr_b", port_b, 32'h0);
        checkOutput("t5_clr_op", {28'h0, aluop}, 32'h0);
        checkOutput("t5_clr_state", {30'h0, entry_state}, 32'd0);
        pressEnter(18'h00001);
        pressEnter(18'h00002);
        checkOutput("t5_in_op", {30'h0, entry_state}, 32'd2);
        applyStimulus(4'hD, 18'h00002, 10);
        applyStimulus(4'hF, 18'h00002, 10);
        checkOutput("t5_back", {30'h0, entry_state}, 32'd1);
        checkOutput("t5_back_a", port_a, 32'h1);
        checkOutput("t5_back_b", port_b, 32'h2);

        // Reset mid-debounce, then the held key counts as a fresh press.
        p0 = pressCnt[0];
        applyStimulus(4'hE, 18'h3ABCD, 4);
        nRST = 1'b0;
        #1;
        checkOutput("t6_async_a", port_a, 32'h0);
        checkOutput("t6_async_state", {30'h0, entry_state}, 32'd0);
        repeat (3) @(negedge CLOCK_50);
        checkOutput("t6_no_pulse_rst", pressCnt[0] - p0, 32'd0);
        nRST = 1'b1;
        rel = cyc;
        repeat (10) @(negedge CLOCK_50);
        checkOutput("t6_pulses", pressCnt[0] - p0, 32'd1);
        checkOutput("t6_pulse_edge", pressCyc[0] - rel, 32'd6);
        checkOutput("t6_port_a", port_a, 32'h0001ABCD);
        checkOutput("t6_state", {30'h0, entry_state}, 32'd1);
        applyStimulus(4'hF, 18'h3ABCD, 10);
        checkOutput("t6_release", pressCnt[0] - p0, 32'd1);
        checkOutput("t6_state_hold", {30'h0, entry_state}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpga_operand_entry.md
Name: fpga_operand_entry

Overview:
- Board input front end for the ALU/processor FPGA build. It is the input-side counterpart of the hex display path.
- Synchronizes the raw SW[17:0] switches and debounces the raw active-low KEY[3:0] buttons into one-cycle press pulses.
- A small state machine steps the user through entering operand A, operand B and an ALU opcode, then presents them with a one-cycle exec_valid strobe.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive synchronized cycles a changed key level must hold before it is accepted (20 ms at 50 MHz).

Ports:
- CLOCK_50  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- KEY  in  4  raw pushbuttons, active-low, asynchronous to CLOCK_50
- SW  in  18  raw slide switches, asynchronous
- key_press  out  4  one-cycle pulse per debounced press
- port_a  out  32  latched operand A
- port_b  out  32  latched operand B
- aluop  out  4  latched opcode (aluop_t)
- exec_valid  out  1  one-cycle strobe: port_a/port_b/aluop are complete
- entry_state  out  2  current state encoding, for LEDG

Behaviour:
- Reset (nRST low, asynchronous):
  - sync flops for KEY = 1; sync flops for SW = 0.
  - debounced key levels = 1 (released); debounce counters = 0.
  - key_press = 0, port_a = 0, port_b = 0, aluop = 0, exec_valid = 0.
  - state = ENTER_A.
- Synchronization:
  - Two-flop synchronizer on every KEY and SW bit.
  - All logic uses only synchronized values.
- Debounce, per key, independent:
  - Synchronized sample equal to debounced level: counter cleared to 0.
  - Sample differs and counter < DEBOUNCE_CYCLES-1: counter increments.
  - Sample differs and counter == DEBOUNCE_CYCLES-1: debounced level flips and counter clears.
  - Any bounce back to the debounced level restarts the count.
- Press pulse:
  - key_press[i] is registered high for exactly one cycle when debounced level i flips 1->0.
  - Release (0->1) produces no pulse.
- Latency: raw KEY low first sampled at edge e0 -> key_press rises at edge e0+DEBOUNCE_CYCLES+1, provided KEY is held stable.
- State machine. Encoding: ENTER_A=0, ENTER_B=1, ENTER_OP=2, SHOW=3.
  - ENTER_A + KEY0 press: port_a <= {15'b0, sw_sync[16:0]}; go ENTER_B.
  - ENTER_B + KEY0: port_b <= {15'b0, sw_sync[16:0]}; go ENTER_OP.
  - ENTER_OP + KEY0: aluop <= sw_sync[3:0]; exec_valid high for the next cycle only; go SHOW.
  - SHOW + KEY0: go ENTER_A; port_a, port_b and aluop are retained until overwritten.
  - KEY1 press (back): SHOW->ENTER_OP, ENTER_OP->ENTER_B, ENTER_B->ENTER_A; ENTER_A stays. No register changes.
  - KEY3 press (clear): port_a, port_b and aluop = 0; state = ENTER_A; exec_valid = 0.
  - KEY2 is reserved: its pulse appears on key_press[2] only, with no state effect.
- Simultaneous presses in one cycle: priority KEY3 > KEY0 > KEY1. Only the highest-priority action is taken.
- SW[17] is synchronized but unused by the state machine (reserved for the register-load mode).
- Reset mid-debounce: counts are lost. A key still held low after reset release is treated as a new press, pulsing DEBOUNCE_CYCLES+2 edges after nRST deasserts.
- Outputs port_a, port_b, aluop, exec_valid and entry_state are all registered, with no combinational path from KEY or SW.

Decomposition:
- Shared package fpga_entry_pkg:
  - entry_state_t enum (ENTER_A, ENTER_B, ENTER_OP, SHOW).
  - KEY_ENTER=0, KEY_BACK=1, KEY_CLEAR=3 index constants.
  - DEBOUNCE_DEFAULT constant.
- aluop_t comes from the existing CPU types package.
- One sub-module key_debouncer (parameter DEBOUNCE_CYCLES): synchronizer, counter, debounced level and press pulse for one key. Instantiated 4 times.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
1. Reset: assert nRST low mid-clock -> all outputs 0 immediately; entry_state=0 after release with KEY=4'hF.
2. SW=18'h12345, KEY0 held low 10 cycles (first sampled at e0) -> single key_press[0] pulse at e0+5; port_a=32'h00012345; entry_state=1.
3. Bounce: KEY0 toggles every 2 cycles for 20 cycles, then returns high -> no key_press pulse; state and registers unchanged.
4. Full entry A=17'h0000F, B=17'h00003, SW[3:0]=4'h2 -> port_a=32'hF, port_b=32'h3, aluop=4'h2, exec_valid high exactly 1 cycle, entry_state=3. Then a KEY0 press -> entry_state=0 with values retained.
5. In ENTER_B, KEY3 and KEY0 pressed so both pulse in the same cycle -> clear wins: port_a=port_b=aluop=0, entry_state=0, port_b not loaded. KEY1 alone in ENTER_OP -> entry_state=1.
6. KEY0 held low, nRST pulsed low when the counter is at 2 -> no pulse during reset; pulse appears 6 edges after nRST release. Releasing KEY0 produces no pulse.
